// File: rtl/pe_sequencer_if.sv
// Control, operand, result and PE-facing bundle of the PE sequencer.
interface pe_sequencer_if #(
  parameter int W = 16
);
  logic                start;
  logic [7:0]          k_len;
  logic                busy;
  logic                done;
  logic                op_valid;
  logic                op_ready;
  logic signed [W-1:0] op_a;
  logic signed [W-1:0] op_b;
  logic                pe_rst_n;
  logic signed [W-1:0] pe_data_in_1;
  logic signed [W-1:0] pe_data_in_2;
  logic [3:0]          pe_add_number;
  logic                pe_rounder_en;
  logic                pe_keep;
  logic signed [W-1:0] pe_data_out;
  logic                res_valid;
  logic                res_ready;
  logic signed [W-1:0] res_data;
  logic [2:0]          res_idx;

  modport slave (
    input  start, k_len, op_valid, op_a, op_b, pe_data_out, res_ready,
    output busy, done, op_ready, pe_rst_n, pe_data_in_1, pe_data_in_2,
           pe_add_number, pe_rounder_en, pe_keep, res_valid, res_data, res_idx
  );

  modport master (
    output start, k_len, op_valid, op_a, op_b, pe_data_out, res_ready,
    input  busy, done, op_ready, pe_rst_n, pe_data_in_1, pe_data_in_2,
           pe_add_number, pe_rounder_en, pe_keep, res_valid, res_data, res_idx
  );
endinterface

// File: rtl/pe_sequencer.sv
// Job sequencer for an 8-slot accumulating PE: clears the PE, streams
// k_len passes of 8 operand pairs into it, reads back the 8 rounded sums
// into a local buffer and drains them over a valid/ready result stream.
module pe_sequencer #(
  parameter int INT_BITS  = 7,
  parameter int FRAC_BITS = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  pe_sequencer_if.slave  bus
);
  localparam int W = INT_BITS + FRAC_BITS;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_MAC, S_READ, S_FLUSH, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [7:0]          klen_q, klen_d;
  logic [7:0]          pass_q, pass_d;
  logic [2:0]          slot_q, slot_d;
  logic [1:0]          tmr_q, tmr_d;

  logic                pe_rst_n_q, pe_rst_n_d;
  logic signed [W-1:0] din1_q, din1_d;
  logic signed [W-1:0] din2_q, din2_d;
  logic [3:0]          add_q, add_d;
  logic                rnd_q, rnd_d;
  logic                keep_q, keep_d;
  logic                done_q, done_d;

  logic                vld_p1, vld_p2, vld_p3;
  logic [2:0]          idx_p1, idx_p2, idx_p3;
  logic signed [W-1:0] buf_q [8];

  logic                hs;
  logic                accept;
  logic                mac_done;

  // MAC keeps one extra cycle after the last pair so that pair's operands
  // reach the PE before the first read slot is presented.
  assign mac_done      = (pass_q == klen_q);
  assign bus.op_ready  = (state_q == S_MAC) && !mac_done;
  assign hs            = bus.op_valid && bus.op_ready;
  assign bus.res_valid = (state_q == S_DRAIN);
  assign accept        = bus.res_valid && bus.res_ready;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.res_idx   = (state_q == S_DRAIN) ? slot_q : 3'd0;
  assign bus.res_data  = (state_q == S_DRAIN) ? buf_q[slot_q] : '0;

  assign bus.pe_rst_n      = pe_rst_n_q;
  assign bus.pe_data_in_1  = din1_q;
  assign bus.pe_data_in_2  = din2_q;
  assign bus.pe_add_number = add_q;
  assign bus.pe_rounder_en = rnd_q;
  assign bus.pe_keep       = keep_q;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      klen_q  <= '0;
      pass_q  <= '0;
      slot_q  <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      pass_q  <= pass_d;
      slot_q  <= slot_d;
      tmr_q   <= tmr_d;
    end
  end

  // Next state and counters; slot_q doubles as MAC slot, read slot and drain index.
  always_comb begin
    state_d = state_q;
    klen_d  = klen_q;
    pass_d  = pass_q;
    slot_d  = slot_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          klen_d  = bus.k_len;
          tmr_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (tmr_q == 2'd1) begin
          tmr_d   = '0;
          slot_d  = '0;
          pass_d  = '0;
          state_d = (klen_q == 8'd0) ? S_READ : S_MAC;
        end else begin
          tmr_d = tmr_q + 2'd1;
        end
      end
      S_MAC: begin
        if (mac_done) begin
          slot_d  = '0;
          state_d = S_READ;
        end else if (hs) begin
          slot_d = slot_q + 3'd1;
          if (slot_q == 3'd7) pass_d = pass_q + 8'd1;
        end
      end
      S_READ: begin
        slot_d = slot_q + 3'd1;
        if (slot_q == 3'd7) begin
          tmr_d   = '0;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (tmr_q == 2'd2) begin
          slot_d  = '0;
          state_d = S_DRAIN;
        end else begin
          tmr_d = tmr_q + 2'd1;
        end
      end
      S_DRAIN: begin
        if (accept) begin
          slot_d = slot_q + 3'd1;
          if (slot_q == 3'd7) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // PE-facing outputs are registered from the next state so they line up
  // with the state they belong to; an accepted pair overrides that for one cycle.
  always_comb begin
    pe_rst_n_d = 1'b1;
    din1_d     = '0;
    din2_d     = '0;
    add_d      = 4'd0;
    rnd_d      = 1'b0;
    keep_d     = 1'b1;
    done_d     = (state_q == S_DRAIN) && accept && (slot_q == 3'd7);
    if ((state_q == S_MAC) && hs) begin
      din1_d = bus.op_a;
      din2_d = bus.op_b;
      add_d  = {1'b0, slot_q};
      keep_d = 1'b0;
    end else begin
      case (state_d)
        S_CLEAR: begin
          pe_rst_n_d = 1'b0;
          keep_d     = 1'b0;
        end
        S_MAC: begin
          add_d  = {1'b0, slot_d};
          keep_d = 1'b0;
        end
        S_READ: begin
          rnd_d  = 1'b1;
          add_d  = {1'b0, slot_d};
          keep_d = 1'b0;
        end
        S_FLUSH: keep_d = 1'b0;
        default: ;
      endcase
    end
  end

  // PE-facing and done output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pe_rst_n_q <= 1'b0;
      din1_q     <= '0;
      din2_q     <= '0;
      add_q      <= 4'd0;
      rnd_q      <= 1'b0;
      keep_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      pe_rst_n_q <= pe_rst_n_d;
      din1_q     <= din1_d;
      din2_q     <= din2_d;
      add_q      <= add_d;
      rnd_q      <= rnd_d;
      keep_q     <= keep_d;
      done_q     <= done_d;
    end
  end

  // Read-slot tags follow the PE's three-cycle rounding latency, then the
  // PE result lands unmodified in the buffer entry of that slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      idx_p1 <= '0;
      idx_p2 <= '0;
      idx_p3 <= '0;
      for (int i = 0; i < 8; i++) buf_q[i] <= '0;
    end else begin
      vld_p1 <= rnd_q;
      idx_p1 <= add_q[2:0];
      // stage p1 -> p2
      vld_p2 <= vld_p1;
      idx_p2 <= idx_p1;
      // stage p2 -> p3
      vld_p3 <= vld_p2;
      idx_p3 <= idx_p2;
      // stage p3 -> buffer
      if (vld_p3) buf_q[idx_p3] <= bus.pe_data_out;
    end
  end
endmodule
